// File: rtl/sim_uart_pkg.sv
// Shared constants and FSM state type for the simulation UART bridge.
// SIM_UART_RX_EN enables the RXDATA harness poll path.
package sim_uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_RXDATA = 2'd2;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_OVF   = 2;

  localparam logic [7:0] UART_RX_NONE = 8'hFF;

`ifdef SIM_UART_RX_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RX_POLL, ST_RESP} uart_state_e;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_RESP} uart_state_e;
`endif

endpackage

// File: rtl/sim_uart_bridge_if.sv
// MMIO request/response handshake between the core device port and the bridge.
interface sim_uart_bridge_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wen;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sim_uart_fifo.sv
// Power-of-two TX FIFO with extra-MSB pointers; head is read combinationally.
module sim_uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/sim_uart_bridge.sv
// Simulation UART bridge: MMIO TXDATA/STATUS/RXDATA to the harness io_uart pins.
// Define SIM_UART_RX_EN to poll the harness on RXDATA reads.
module sim_uart_bridge
  import sim_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TX_GAP     = 4
) (
  input  logic               clock,
  input  logic               reset,
  sim_uart_bridge_if.slave   bus,
  output logic               io_uart_out_valid,
  output logic [7:0]         io_uart_out_ch,
  output logic               io_uart_in_valid,
  input  logic [7:0]         io_uart_in_ch
);
  localparam int unsigned GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(TX_GAP - 1);

  uart_state_e      state_q, state_d;
  logic             resp_valid_q, resp_valid_d;
  logic [7:0]       resp_rdata_q, resp_rdata_d;
  logic             in_valid_q, in_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_ch_q, out_ch_d;
  logic             overflow_q, overflow_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic       accept, tx_write, status_read;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_head, read_data;

  assign accept      = bus.req_valid && (state_q == ST_IDLE);
  assign tx_write    = accept && bus.req_wen && (bus.req_addr == UART_TXDATA);
  assign status_read = accept && !bus.req_wen && (bus.req_addr == UART_STATUS);
  assign fifo_pop    = !fifo_empty && (gap_q == '0);
  // A full FIFO still takes the byte when the head leaves in the same cycle.
  assign fifo_push   = tx_write && (!fifo_full || fifo_pop);

  sim_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.req_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    read_data = '0;
    if (!bus.req_wen) begin
      case (bus.req_addr)
        UART_STATUS: begin
          read_data[STAT_FULL]  = fifo_full;
          read_data[STAT_EMPTY] = fifo_empty;
          read_data[STAT_OVF]   = overflow_q;
        end
        UART_RXDATA: read_data = UART_RX_NONE;
        default:     read_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    in_valid_d   = 1'b0;
    overflow_d   = overflow_q;
    out_valid_d  = fifo_pop;
    out_ch_d     = fifo_pop ? fifo_head : out_ch_q;
    if (fifo_pop)          gap_d = GAP_RELOAD;
    else if (gap_q != '0)  gap_d = gap_q - 1'b1;
    else                   gap_d = '0;

    if (tx_write && fifo_full && !fifo_pop) overflow_d = 1'b1;
    if (status_read)                        overflow_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef SIM_UART_RX_EN
          if (!bus.req_wen && (bus.req_addr == UART_RXDATA)) begin
            state_d    = ST_RX_POLL;
            in_valid_d = 1'b1;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = read_data;
          end
`else
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = read_data;
`endif
        end
      end
`ifdef SIM_UART_RX_EN
      ST_RX_POLL: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = io_uart_in_ch;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      in_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      overflow_q   <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      in_valid_q   <= in_valid_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      overflow_q   <= overflow_d;
      gap_q        <= gap_d;
    end
  end

`ifndef SIM_UART_RX_EN
  logic unused_in_ch;
  assign unused_in_ch = ^io_uart_in_ch;
`endif

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign io_uart_in_valid  = in_valid_q;
endmodule
